mem_read_arbiter: RTL

Shares the single AXI read channel to main memory between several read masters: I-cache refill, I-side stream buffer prefetch and D-cache refill. It accepts one burst request at a time, forwards it on `mem_read_address`, then steers every returned beat on `mem_read_data` to the owning requester until the burst completes. Exactly one burst is outstanding at any time.

---
 rtl/mem_read_arbiter_pkg.sv | 22 ++
 rtl/mem_read_arbiter_if.sv | 26 ++
 rtl/mem_read_arbiter_rr.sv | 64 ++++++
 rtl/mem_read_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the memory read arbiter.
// ADDR_WIDTH defaults to 32 when not supplied by the build.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ID_W    = 4;

  localparam int REQ_ICACHE  = 0;
  localparam int REQ_SBUF    = 1;
  localparam int REQ_DCACHE  = 2;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// AXI read address and read data channel bundles used on the memory side.
interface axi_read_address #(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [ID_W-1:0]   arid;

  modport master (output arvalid, output araddr, output arlen, output arid, input arready);
  modport slave  (input arvalid, input araddr, input arlen, input arid, output arready);
endinterface

interface axi_read_data #(
  parameter int DATA_W = 32
);
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;

  modport master (input rvalid, input rdata, output rready);
  modport slave  (output rvalid, output rdata, input rready);
endinterface

// File: rtl/mem_read_arbiter_rr.sv
// One-hot grant generator. MEM_ARB_RR_EN selects round-robin with a
// last-winner pointer; otherwise fixed priority, lowest index wins.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
`ifdef MEM_ARB_RR_EN
  input  logic               clk,
  input  logic               rst,
  input  logic               i_adv,
`endif
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W + 1)'(i);
      if (w_sum >= (IDX_W + 1)'(NUM_REQ))
        w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
      w_idx = w_sum[IDX_W-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (i_adv) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (o_grant[i]) r_ptr <= IDX_W'(i);
    end
  end
`else
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_read_arbiter.sv
// Single-outstanding-burst AXI read arbiter; steers returned beats to the owner.
// Arbitration policy chosen by MEM_ARB_RR_EN (round-robin) or fixed priority.
//
// state | meaning
// IDLE  | waiting for any req_arvalid; winner accepted and latched this cycle
// ADDR  | ARVALID driven with latched addr/len/id until ARREADY
// DATA  | beats passed through to the owner until len beats are counted
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = `ADDR_WIDTH,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_arlen,
  input  logic [NUM_REQ*ID_W-1:0]   req_arid,
  output logic [NUM_REQ-1:0]        req_arready,
  output logic [NUM_REQ-1:0]        req_rvalid,
  output logic [DATA_W-1:0]         req_rdata,
  input  logic [NUM_REQ-1:0]        req_rready,
  axi_read_address.master           mem_read_address,
  axi_read_data.master              mem_read_data
);

  state_t              r_state;
  state_t              w_next;
  logic [NUM_REQ-1:0]  r_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [ID_W-1:0]     r_id;
  logic [LEN_W-1:0]    r_cnt;

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [LEN_W-1:0]    w_sel_len;
  logic [ID_W-1:0]     w_sel_id;
  logic                w_rready;
  logic                w_beat;
  logic                w_last;

  assign w_accept = (r_state == ST_IDLE) && (|req_arvalid);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef MEM_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .i_adv   (w_accept),
`endif
    .i_req   (req_arvalid),
    .o_grant (w_grant)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    w_sel_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req_araddr[i*ADDR_W +: ADDR_W];
        w_sel_len  = req_arlen[i*LEN_W +: LEN_W];
        w_sel_id   = req_arid[i*ID_W +: ID_W];
      end
    end
  end

  assign w_rready = (r_state == ST_DATA) && (|(r_grant & req_rready));
  assign w_beat   = mem_read_data.rvalid && w_rready;
  assign w_last   = (r_cnt == r_len - LEN_W'(1));

  always_comb begin
    w_next      = r_state;
    req_arready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          req_arready = w_grant;
          w_next      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (mem_read_address.arready) w_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_beat && w_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_grant <= w_grant;
            r_addr  <= w_sel_addr;
            // A zero-length request still moves one beat.
            r_len   <= (w_sel_len == '0) ? LEN_W'(1) : w_sel_len;
            r_id    <= w_sel_id;
          end
        end
        ST_ADDR: begin
          if (mem_read_address.arready) r_cnt <= '0;
        end
        ST_DATA: begin
          if (w_beat) begin
            if (w_last) r_grant <= '0;
            else        r_cnt   <= r_cnt + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_read_address.arvalid = (r_state == ST_ADDR);
  assign mem_read_address.araddr  = r_addr;
  assign mem_read_address.arlen   = r_len;
  assign mem_read_address.arid    = r_id;

  assign mem_read_data.rready = w_rready;
  assign req_rvalid = (r_state == ST_DATA) ? (r_grant & {NUM_REQ{mem_read_data.rvalid}}) : '0;
  assign req_rdata  = mem_read_data.rdata;

endmodule
